// File: rtl/hit_collector.sv
// hit_collector: buffers IDs of hit vectors in a FIFO and streams them out with per-batch TLAST, hit count and overflow flag
module hit_collector #(
  parameter int VEC_ID_WIDTH  = 16,
  parameter int FIFO_DEPTH    = 64,
  parameter int HIT_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_Valid,
  input  logic                     i_Hit,
  input  logic [VEC_ID_WIDTH-1:0]  i_ID,
  input  logic                     i_Last,
  output logic [VEC_ID_WIDTH-1:0]  o_TData,
  output logic                     o_TUser,
  output logic                     o_TLast,
  output logic                     o_TValid,
  input  logic                     i_TReady,
  output logic [HIT_CNT_WIDTH-1:0] o_HitCount,
  output logic                     o_Overflow,
  output logic                     o_Done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = VEC_ID_WIDTH + 2;
  localparam logic [AW:0] NONLAST_LIM = (AW + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                   state, state_nx;
  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [EW-1:0]            head, push_data;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     accept, push, pop, drop, violation;
  logic [HIT_CNT_WIDTH-1:0] cnt_base;
  logic                     ovf_base;

  // Entries are {last, user, id}; outputs are forced to zero when the FIFO is empty
  assign head     = mem[rd_ptr];
  assign o_TValid = count != '0;
  assign o_TData  = o_TValid ? head[VEC_ID_WIDTH-1:0] : '0;
  assign o_TUser  = o_TValid & head[VEC_ID_WIDTH];
  assign o_TLast  = o_TValid & head[VEC_ID_WIDTH+1];
  assign o_Done   = state == DONE;

  // Accept/push/drop decisions and next state; the top FIFO slot is kept free for the batch-closing entry
  always_comb begin
    accept    = i_Valid && (state == IDLE || state == COLLECT);
    violation = i_Valid && !accept;
    push      = accept && (i_Last || (i_Hit && count < NONLAST_LIM));
    drop      = accept && i_Hit && !push;
    push_data = i_Hit ? {i_Last, 1'b0, i_ID} : {2'b11, {VEC_ID_WIDTH{1'b0}}};
    pop       = o_TValid && i_TReady;
    cnt_base  = state == IDLE ? '0 : o_HitCount;
    ovf_base  = state == IDLE ? 1'b0 : o_Overflow;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = accept ? (i_Last ? DRAIN : COLLECT) : IDLE;
      COLLECT: state_nx = (accept && i_Last) ? DRAIN : COLLECT;
      DRAIN:   state_nx = (pop && o_TLast) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy gates everything read from it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // State, FIFO pointers and per-batch statistics
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_HitCount <= '0;
      o_Overflow <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      if (accept) begin
        o_HitCount <= (i_Hit && ~&cnt_base) ? cnt_base + 1'b1 : cnt_base;
        o_Overflow <= ovf_base | drop;
      end else if (violation) begin
        o_Overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hit_collector.sv
// tb_hit_collector: directed self-checking bench for hit_collector
module tb_hit_collector;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_Valid = 1'b0, i_Hit = 1'b0, i_Last = 1'b0, i_TReady = 1'b0;
  logic [15:0] i_ID = '0;
  logic [15:0] o_TData;
  logic        o_TUser, o_TLast, o_TValid, o_Overflow, o_Done;
  logic [31:0] o_HitCount;
  logic [17:0] beat;
  logic [17:0] q[$];
  logic [17:0] prev_beat;
  logic        prev_stall = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  hit_collector dut (
    .clk(clk), .rstn(rstn), .i_Valid(i_Valid), .i_Hit(i_Hit), .i_ID(i_ID), .i_Last(i_Last),
    .o_TData(o_TData), .o_TUser(o_TUser), .o_TLast(o_TLast), .o_TValid(o_TValid),
    .i_TReady(i_TReady), .o_HitCount(o_HitCount), .o_Overflow(o_Overflow), .o_Done(o_Done)
  );

  always #5 clk = ~clk;
  assign beat = {o_TLast, o_TUser, o_TData};

  // Records accepted beats, counts Done pulses and checks that stalled beats hold steady
  always @(posedge clk) begin
    if (rstn && prev_stall) begin
      total++;
      assert (o_TValid === 1'b1 && beat === prev_beat) else begin
        bad++;
        $error("FAIL stall_stable obs=%0h/%0b exp=%0h/1", beat, o_TValid, prev_beat);
      end
    end
    prev_stall = rstn && o_TValid && !i_TReady;
    prev_beat  = beat;
    if (rstn && o_TValid && i_TReady) q.push_back(beat);
    if (o_Done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] id, input logic hit, input logic last);
    i_Valid = 1'b1;
    i_ID    = id;
    i_Hit   = hit;
    i_Last  = last;
    tick();
    i_Valid = 1'b0;
    i_Hit   = 1'b0;
    i_Last  = 1'b0;
  endtask

  task automatic wait_done(input int n, input logic rnd);
    for (int c = 0; c < 400 && done_cnt < n; c++) begin
      if (rnd) i_TReady = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_pulses", 32'(done_cnt), 32'(n));
  endtask

  function automatic logic [31:0] qat(input int i);
    return q.size() > i ? {14'd0, q[i]} : 32'hffff_ffff;
  endfunction

  function automatic int tlast_cnt();
    int n = 0;
    foreach (q[i]) if (q[i][17]) n++;
    return n;
  endfunction

  task automatic batch1(input string tag);
    q.delete();
    done_cnt = 0;
    i_TReady = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(i), i == 2 || i == 5 || i == 7, i == 7);
    wait_done(1, 1'b0);
    chk({tag, "_size"}, 32'(q.size()), 32'd3);
    chk({tag, "_b0"}, qat(0), {14'd0, 2'b00, 16'd2});
    chk({tag, "_b1"}, qat(1), {14'd0, 2'b00, 16'd5});
    chk({tag, "_b2"}, qat(2), {14'd0, 2'b10, 16'd7});
    chk({tag, "_hits"}, o_HitCount, 32'd3);
    chk({tag, "_ovf"}, {31'd0, o_Overflow}, 32'd0);
  endtask

  initial begin
    int errs;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, o_TValid}, 32'd0);
    chk("rst_tdata", {16'd0, o_TData}, 32'd0);
    chk("rst_tuser_tlast", {30'd0, o_TUser, o_TLast}, 32'd0);
    chk("rst_hits", o_HitCount, 32'd0);
    chk("rst_ovf_done", {30'd0, o_Overflow, o_Done}, 32'd0);
    rstn = 1'b1;
    tick();

    batch1("t1");

    q.delete();
    done_cnt = 0;
    for (int i = 0; i < 4; i++) send(16'(i), 1'b0, i == 3);
    wait_done(1, 1'b0);
    chk("t2_size", 32'(q.size()), 32'd1);
    chk("t2_term", qat(0), {14'd0, 2'b11, 16'd0});
    chk("t2_hits", o_HitCount, 32'd0);
    chk("t2_ovf", {31'd0, o_Overflow}, 32'd0);

    q.delete();
    done_cnt = 0;
    i_TReady = 1'b0;
    for (int i = 0; i < 100; i++) send(16'(100 + i), 1'b1, 1'b0);
    send(16'd500, 1'b1, 1'b1);
    tick();
    chk("t3_hits", o_HitCount, 32'd101);
    chk("t3_ovf", {31'd0, o_Overflow}, 32'd1);
    chk("t3_head", {15'd0, o_TValid, o_TData}, {15'd0, 1'b1, 16'd100});
    i_TReady = 1'b1;
    wait_done(1, 1'b0);
    chk("t3_size", 32'(q.size()), 32'd64);
    chk("t3_first", qat(0), {14'd0, 2'b00, 16'd100});
    chk("t3_b62", qat(62), {14'd0, 2'b00, 16'd162});
    chk("t3_b63", qat(63), {14'd0, 2'b10, 16'd500});
    chk("t3_tlasts", 32'(tlast_cnt()), 32'd1);
    chk("t3_ovf_hold", {31'd0, o_Overflow}, 32'd1);

    q.delete();
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      i_TReady = 1'($urandom_range(0, 1));
      send(16'(1000 + i), 1'b1, i == 29);
    end
    wait_done(1, 1'b1);
    i_TReady = 1'b1;
    chk("t4_size", 32'(q.size()), 32'd30);
    errs = 0;
    for (int i = 0; i < 30; i++)
      if (qat(i) !== {14'd0, 1'(i == 29), 1'b0, 16'(1000 + i)}) errs++;
    chk("t4_order", 32'(errs), 32'd0);
    chk("t4_hits", o_HitCount, 32'd30);
    chk("t4_ovf", {31'd0, o_Overflow}, 32'd0);

    q.delete();
    done_cnt = 0;
    i_TReady = 1'b0;
    send(16'd7, 1'b1, 1'b0);
    send(16'd8, 1'b1, 1'b0);
    send(16'd9, 1'b1, 1'b0);
    chk("t5_buffered", {15'd0, o_TValid, o_TData}, {15'd0, 1'b1, 16'd7});
    chk("t5_hits_pre", o_HitCount, 32'd3);
    rstn = 1'b0;
    tick();
    chk("t5_tvalid", {31'd0, o_TValid}, 32'd0);
    chk("t5_hits", o_HitCount, 32'd0);
    rstn = 1'b1;
    i_TReady = 1'b1;
    tick();
    tick();
    chk("t5_no_tlast", 32'(q.size() + done_cnt), 32'd0);
    batch1("t5b");

    q.delete();
    done_cnt = 0;
    i_TReady = 1'b0;
    send(16'd1, 1'b1, 1'b0);
    send(16'd2, 1'b1, 1'b1);
    chk("t6_ovf_pre", {31'd0, o_Overflow}, 32'd0);
    send(16'd9, 1'b1, 1'b0);
    chk("t6_ovf", {31'd0, o_Overflow}, 32'd1);
    chk("t6_hits", o_HitCount, 32'd2);
    i_TReady = 1'b1;
    wait_done(1, 1'b0);
    chk("t6_size", 32'(q.size()), 32'd2);
    chk("t6_b0", qat(0), {14'd0, 2'b00, 16'd1});
    chk("t6_b1", qat(1), {14'd0, 2'b10, 16'd2});
    tick();
    chk("t6_idle_done", {31'd0, o_Done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
